display_manager: RTL
====================

Name: display_manager

Overview:
Output end of the number-entry path. Accepts a 12-bit binary result (the adder sum or an entered number) through a load/busy handshake. Converts it to four BCD digits with a sequential double-dabble. Drives a 4-digit multiplexed common-anode 7-segment display continuously from the last converted value.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot; the bench uses 4; legal range >= 2.
NUM_DIGITS, 4, digits scanned; fixed at 4 for a 12-bit input (max 4095).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset; sampled on the clk rising edge
number_in  input  12  binary value to display
load  input  1  request; sampled only in IDLE
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when the new value is latched for display
an  output  4  digit enables, active-low, one-hot-low; an[0] is units
seg  output  7  {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (reset==0 at an edge):
  - an=4'b1111, seg=7'b1111111, busy=0, done=0.
  - Display BCD register = 0, refresh counter = 0, digit index = 0, state = IDLE.
  - Reset mid-conversion aborts it; the display reverts to 0.
- FSM states: IDLE, CONVERT, LATCH.
- IDLE:
  - load=1 at an edge captures number_in into a shift register and clears the 16-bit BCD scratch and the bit counter.
  - Next state is CONVERT; busy=1 from the following cycle.
- CONVERT:
  - Exactly 12 cycles.
  - Each cycle: every scratch nibble >= 5 gets +3, then {scratch, shift} shifts left by 1.
  - After the 12th shift, go to LATCH.
- LATCH:
  - Scratch is copied to the display register.
  - done=1 for this single cycle; busy=0 from this cycle on.
  - Next state is IDLE.
- Latency: done is high in the 13th cycle after the edge that sampled load. A back-to-back load is accepted on the cycle after done.
- load while busy (CONVERT or LATCH): ignored, not queued.
- Refresh:
  - The counter runs 0..REFRESH_DIV-1 regardless of FSM state.
  - On wrap, the digit index advances 0→1→2→3→0.
- an and seg are registered from the current index and display register, so they lag the index by one cycle.
  - Index 0 → an=1110; index 3 → an=0111.
- Display update is atomic in LATCH; no digit ever shows half-converted data.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles > 9 are unreachable; the decoder default is blank (1111111).

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: each digit above the most significant non-zero digit outputs seg=1111111; its an is still driven in its slot. The units digit is never blanked, so value 0 shows "0".
- Undefined: all four digits are always shown, e.g. "0007".

Decomposition:
- Package display_pkg:
  - state enum (IDLE, CONVERT, LATCH)
  - NUM_DIGITS, BIN_W=12, BCD_W=16
  - SEG_BLANK constant
  - 10-entry segment code table as constants
- Sub-module seg7_decoder: combinational, 4-bit BCD plus blank flag → 7-bit seg, using the package table.

Test Plan:
1. reset=0 for 2 cycles, load=1 → an=1111, seg=1111111, busy=0, done=0; no conversion starts.
2. REFRESH_DIV=4, load=1 with number_in=321 for one cycle → busy=1 next cycle; done pulses exactly 13 cycles after the load edge. The scan then shows:
   - an=1110 seg=1111001
   - an=1101 seg=0100100
   - an=1011 seg=0110000
   - an=0111 seg=1000000
3. load 4095 → display digits 4,0,9,5: an=0111 seg=0011001, an=1110 seg=0010010.
4. load 123, then hold load=1 with number_in=999 during busy → single done; display shows 0123; a 999 load sampled after done then converts normally.
5. load 850, assert reset=0 at cycle 6 of CONVERT → all outputs return to reset values; after release, the scan shows 0000 and no done is seen.
6. With LEADING_ZERO_BLANK_EN, load 7 → an=1110 seg=1111000; other slots seg=1111111. Load 0 → units seg=1000000, others blank.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display_manager output path:
// FSM state encoding, data widths, segment code table and the
// double-dabble step used by the binary-to-BCD converter.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LATCH
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 12;
  localparam int BCD_W      = 16;

  // Segment order is {g,f,e,d,c,b,a}; a lit segment is driven low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // One double-dabble iteration: correct every BCD nibble that would
  // overflow past 9 when doubled, then shift {bcd, bin} left by one.
  function automatic logic [BCD_W+BIN_W-1:0] dabble_step(
    input logic [BCD_W-1:0] bcd,
    input logic [BIN_W-1:0] bin
  );
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    return {adj, bin} << 1;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern.
// The blank flag, or any nibble above 9, yields an unlit digit.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Look the digit up in the shared code table; default is blank.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_TABLE[0];
        4'd1:    seg = SEG_TABLE[1];
        4'd2:    seg = SEG_TABLE[2];
        4'd3:    seg = SEG_TABLE[3];
        4'd4:    seg = SEG_TABLE[4];
        4'd5:    seg = SEG_TABLE[5];
        4'd6:    seg = SEG_TABLE[6];
        4'd7:    seg = SEG_TABLE[7];
        4'd8:    seg = SEG_TABLE[8];
        4'd9:    seg = SEG_TABLE[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/display_manager.sv
// Output end of the number-entry path: accepts a 12-bit binary value
// over a load/busy handshake, converts it to four BCD digits with a
// sequential double-dabble (12 shift cycles), and scans the last
// converted value onto a 4-digit multiplexed common-anode display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the
// most significant non-zero digit (units digit is always shown).
module display_manager
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      number_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0]       LAST_BIT = 4'(BIN_W - 1);

  state_t           state;
  logic [BIN_W-1:0] shift_reg;
  logic [BCD_W-1:0] scratch;
  logic [3:0]       bit_cnt;
  logic [BCD_W-1:0] disp_bcd;
  logic [CNT_W-1:0] refresh_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic [3:0]       cur_nibble;
  logic             digit_blank;
  logic [6:0]       dec_seg;

  // Conversion FSM: capture in IDLE, 12 dabble shifts, then publish.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      disp_bcd  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= number_in;
            scratch   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          {scratch, shift_reg} <= dabble_step(scratch, shift_reg);
          bit_cnt              <= bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= LATCH;
          end
        end
        LATCH: begin
          disp_bcd <= scratch;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur_nibble = disp_bcd[4*digit_idx +: 4];

  // Decide whether the digit in the current slot is a suppressed leading zero.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    digit_blank = (digit_idx != '0) && ((disp_bcd >> (4 * digit_idx)) == '0);
`else
    digit_blank = 1'b0;
`endif
  end

  seg7_decoder u_decoder (
    .bcd   (cur_nibble),
    .blank (digit_blank),
    .seg   (dec_seg)
  );

  // Free-running slot timer and registered anode/segment drive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      an          <= '1;
      seg         <= SEG_BLANK;
    end else begin
      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an  <= ~(NUM_DIGITS'(1) << digit_idx);
      seg <= dec_seg;
    end
  end

endmodule
